mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single tagged memory port between instruction fetch and the data side (load/store queue) of the 2-way superscalar core. Each cycle it grants the port to one requester, with data-side priority and starvation protection for fetch. It records which requester owns each outstanding load tag and routes returning data to that requester one cycle later. It generates `memory_structure_hazard_stall` for the PC/fetch stage whenever fetch is requesting but not accepted.

## Interface
Parameters:
- `NUM_TAGS`, 15 — usable memory tags (1..15); tag 0 means "no tag/rejected".
- `STARVE_LIMIT`, 4 — consecutive denied fetch cycles before fetch is forced to win.

Ports:
- `clock` in 1 — system clock, rising edge.
- `reset` in 1 — asynchronous, active-low; asserted when 0.
- `Icache2mem_req` in 1 — fetch requests a 64-bit load.
- `Icache2mem_addr` in 64 — fetch address.
- `Dcache2mem_command` in 2 — data command: 0 none, 1 load, 2 store; 3 is illegal and treated as none.
- `Dcache2mem_addr` in 64 — data address.
- `Dcache2mem_data` in 64 — store data.
- `proc2mem_command` out 2 — command to memory.
- `proc2mem_addr` out 64 — address to memory.
- `proc2mem_data` out 64 — store data to memory.
- `mem2proc_response` in 4 — same-cycle accept tag; 0 means rejected.
- `mem2proc_data` in 64 — returned load data.
- `mem2proc_tag` in 4 — tag of returned data; 0 means no return this cycle.
- `Imem2proc_response` out 4 — accept tag for fetch; 0 when fetch is not granted or is rejected.
- `Imem2proc_valid` out 1 — fetch data return valid.
- `Imem2proc_data` out 64 — fetch return data.
- `Imem2proc_tag` out 4 — fetch return tag.
- `Dmem2proc_response` out 4 — accept tag for data side.
- `Dmem2proc_valid` out 1 — data return valid.
- `Dmem2proc_data` out 64 — data return data.
- `Dmem2proc_tag` out 4 — data return tag.
- `memory_structure_hazard_stall` out 1 — fetch requested but not accepted this cycle.
- `tag_error` out 1 — sticky flag: a tag returned with no recorded owner.

## Operation
Grant (combinational):
- Data wins when `Dcache2mem_command` is 1 or 2, unless `starve_cnt == STARVE_LIMIT` and `Icache2mem_req` is high; in that case fetch wins.
- With no data request, fetch wins if it is requesting. Otherwise the port is idle: command 0, address 0, data 0.
- A fetch grant drives command 1 with `Icache2mem_addr`; `proc2mem_data` is 0.
- `Imem2proc_response`/`Dmem2proc_response` = `mem2proc_response` for the granted side, 0 for the other side.
- `memory_structure_hazard_stall` = `Icache2mem_req` and (fetch not granted or `mem2proc_response == 0`).

Starvation counter `starve_cnt` (3 bits, saturating at `STARVE_LIMIT`):
- Increments when fetch requests and is not accepted.
- Clears to 0 when fetch is accepted or fetch does not request.

Owner table, entries 1..15, each holding {valid, is_data}:
- An accepted load (fetch or data load) sets entry[`mem2proc_response`] = {1, owner}.
- An accepted store records nothing.
- A return with `mem2proc_tag != 0`:
  - valid entry: capture data and tag into the owner's return registers, pulse that side's valid, clear the entry.
  - invalid entry: drop the data, set `tag_error`.
- Same-cycle return and accept on the same tag: the clear is applied first and the new set wins, so the entry stays valid.

## Timing
- Grant, `proc2mem_*`, `*_response` and stall are combinational in the same cycle as the request.
- Return latency: `*mem2proc_valid/data/tag` are registered, one cycle after `mem2proc_tag`. Valid is a one-cycle pulse, and at most one side is valid per cycle.
- Reset (asynchronous, low): owner table cleared, `starve_cnt = 0`, `tag_error = 0`, all registered return outputs 0.
- Combinational outputs are 0 during reset when there are no requests.
- Reset mid-operation forgets all outstanding tags. Later returns on those tags set `tag_error`.
- Back-to-back grants are allowed every cycle. Up to 15 loads may be outstanding; tag reuse is governed by memory.

## Test plan
- Fetch only, addr 0x100, response 3 → `Imem2proc_response = 3`, stall = 0. Tag 3 returns 0x1234_4567_5678_3456 → next cycle `Imem2proc_valid = 1`, data matches, tag = 3.
- Fetch and data load together, response 5 → data granted, `Dmem2proc_response = 5`, `Imem2proc_response = 0`, stall = 1. Return tag 5 → `Dmem2proc_valid` pulse only.
- Fetch plus continuous data stores for 6 cycles, always accepted → stall for 4 cycles. Fetch is granted on the 5th cycle (counter saturated), and the counter clears.
- `mem2proc_response = 0` with fetch granted → stall = 1 and the counter increments. A store accepted with tag 7 → no owner entry; a later return on tag 7 sets `tag_error`.
- Tag 9 returns while a new load is accepted on tag 9 → old data routed to its owner. Entry 9 stays valid for the new owner.
- Reset pulled low with 3 loads outstanding → all outputs 0 immediately. Later returns set `tag_error` and produce no valid pulse.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between fetch, the data side, memory and the arbiter.
// The slave modport is the arbiter's view; master is the mirror used by the surrounding logic.
interface mem_arbiter_if;
    logic        Icache2mem_req;
    logic [63:0] Icache2mem_addr;
    logic [1:0]  Dcache2mem_command;
    logic [63:0] Dcache2mem_addr;
    logic [63:0] Dcache2mem_data;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [3:0]  Imem2proc_response;
    logic        Imem2proc_valid;
    logic [63:0] Imem2proc_data;
    logic [3:0]  Imem2proc_tag;
    logic [3:0]  Dmem2proc_response;
    logic        Dmem2proc_valid;
    logic [63:0] Dmem2proc_data;
    logic [3:0]  Dmem2proc_tag;
    logic        memory_structure_hazard_stall;
    logic        tag_error;

    modport slave (
        input  Icache2mem_req, Icache2mem_addr, Dcache2mem_command, Dcache2mem_addr,
               Dcache2mem_data, mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data, Imem2proc_response,
               Imem2proc_valid, Imem2proc_data, Imem2proc_tag, Dmem2proc_response,
               Dmem2proc_valid, Dmem2proc_data, Dmem2proc_tag, memory_structure_hazard_stall,
               tag_error
    );

    modport master (
        output Icache2mem_req, Icache2mem_addr, Dcache2mem_command, Dcache2mem_addr,
               Dcache2mem_data, mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, Imem2proc_response,
               Imem2proc_valid, Imem2proc_data, Imem2proc_tag, Dmem2proc_response,
               Dmem2proc_valid, Dmem2proc_data, Dmem2proc_tag, memory_structure_hazard_stall,
               tag_error
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one tagged memory port between fetch and the data side, with data priority,
// fetch starvation protection and per-tag routing of returned load data.
module mem_arbiter #(
    parameter int unsigned NUM_TAGS     = 15,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam logic [2:0] StarveMax = 3'(STARVE_LIMIT);

    logic d_req, d_load, fetch_win, data_win, accepted, load_accept, stall;
    logic ret_valid, ret_hit;

    logic [2:0]        starve_cnt_q, starve_cnt_d;
    logic [NUM_TAGS:0] valid_q, valid_d;
    logic [NUM_TAGS:0] is_data_q, is_data_d;
    logic              tag_error_q, tag_error_d;

    logic              i_valid_q, i_valid_d, d_valid_q, d_valid_d;
    logic [63:0]       i_data_q, i_data_d, d_data_q, d_data_d;
    logic [3:0]        i_tag_q, i_tag_d, d_tag_q, d_tag_d;

    // Grant: fetch only overrides a data request once it has been denied STARVE_LIMIT times.
    always_comb begin
        d_req     = (bus.Dcache2mem_command == 2'd1) || (bus.Dcache2mem_command == 2'd2);
        d_load    = (bus.Dcache2mem_command == 2'd1);
        fetch_win = bus.Icache2mem_req && (!d_req || (starve_cnt_q == StarveMax));
        data_win  = d_req && !fetch_win;
        accepted  = (bus.mem2proc_response != 4'd0);
        stall     = bus.Icache2mem_req && !(fetch_win && accepted);
        load_accept = accepted && (fetch_win || (data_win && d_load));
    end

    always_comb begin
        bus.proc2mem_command = 2'd0;
        bus.proc2mem_addr    = 64'd0;
        bus.proc2mem_data    = 64'd0;
        if (fetch_win) begin
            bus.proc2mem_command = 2'd1;
            bus.proc2mem_addr    = bus.Icache2mem_addr;
        end else if (data_win) begin
            bus.proc2mem_command = bus.Dcache2mem_command;
            bus.proc2mem_addr    = bus.Dcache2mem_addr;
            bus.proc2mem_data    = bus.Dcache2mem_data;
        end
        bus.Imem2proc_response            = fetch_win ? bus.mem2proc_response : 4'd0;
        bus.Dmem2proc_response            = data_win ? bus.mem2proc_response : 4'd0;
        bus.memory_structure_hazard_stall = stall;
        bus.Imem2proc_valid               = i_valid_q;
        bus.Imem2proc_data                = i_data_q;
        bus.Imem2proc_tag                 = i_tag_q;
        bus.Dmem2proc_valid               = d_valid_q;
        bus.Dmem2proc_data                = d_data_q;
        bus.Dmem2proc_tag                 = d_tag_q;
        bus.tag_error                     = tag_error_q;
    end

    always_comb begin
        if (!stall) begin
            starve_cnt_d = 3'd0;
        end else if (starve_cnt_q == StarveMax) begin
            starve_cnt_d = starve_cnt_q;
        end else begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end

        ret_valid   = (bus.mem2proc_tag != 4'd0);
        ret_hit     = ret_valid && valid_q[bus.mem2proc_tag];
        tag_error_d = tag_error_q || (ret_valid && !valid_q[bus.mem2proc_tag]);

        // Clear on return before set on accept, so a reused tag stays owned.
        valid_d   = valid_q;
        is_data_d = is_data_q;
        if (ret_hit) begin
            valid_d[bus.mem2proc_tag] = 1'b0;
        end
        if (load_accept) begin
            valid_d[bus.mem2proc_response]   = 1'b1;
            is_data_d[bus.mem2proc_response] = data_win;
        end

        i_valid_d = ret_hit && !is_data_q[bus.mem2proc_tag];
        d_valid_d = ret_hit && is_data_q[bus.mem2proc_tag];
        i_data_d  = i_valid_d ? bus.mem2proc_data : i_data_q;
        i_tag_d   = i_valid_d ? bus.mem2proc_tag : i_tag_q;
        d_data_d  = d_valid_d ? bus.mem2proc_data : d_data_q;
        d_tag_d   = d_valid_d ? bus.mem2proc_tag : d_tag_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= 3'd0;
            valid_q      <= '0;
            is_data_q    <= '0;
            tag_error_q  <= 1'b0;
            i_valid_q    <= 1'b0;
            i_data_q     <= 64'd0;
            i_tag_q      <= 4'd0;
            d_valid_q    <= 1'b0;
            d_data_q     <= 64'd0;
            d_tag_q      <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            valid_q      <= valid_d;
            is_data_q    <= is_data_d;
            tag_error_q  <= tag_error_d;
            i_valid_q    <= i_valid_d;
            i_data_q     <= i_data_d;
            i_tag_q      <= i_tag_d;
            d_valid_q    <= d_valid_d;
            d_data_q     <= d_data_d;
            d_tag_q      <= d_tag_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a driver applies directed then random traffic against a
// tag-ownership model; a monitor pops expected returns whenever the DUT pulses a valid.
module tb_mem_arbiter;
    localparam int LIMIT = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_arbiter_if bus();

    mem_arbiter #(
        .NUM_TAGS    (15),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit          is_data;
        logic [63:0] data;
        logic [3:0]  tag;
        int          due;
    } ret_t;

    ret_t        exp_q[$];
    ret_t        mon_e;
    int          owner[16];   // -1 free, 0 fetch, 1 data
    int          starve;
    bit          exp_tag_err;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        obs_stall;
    logic [1:0]  obs_cmd;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) owner[i] = -1;
        starve      = 0;
        exp_tag_err = 1'b0;
        exp_q.delete();
    endfunction

    task automatic drive(input bit ireq, input logic [63:0] iaddr, input logic [1:0] dcmd,
                         input logic [63:0] daddr, input logic [63:0] ddata,
                         input logic [3:0] resp, input logic [3:0] rtag,
                         input logic [63:0] rdata);
        bus.Icache2mem_req     = ireq;
        bus.Icache2mem_addr    = iaddr;
        bus.Dcache2mem_command = dcmd;
        bus.Dcache2mem_addr    = daddr;
        bus.Dcache2mem_data    = ddata;
        bus.mem2proc_response  = resp;
        bus.mem2proc_tag       = rtag;
        bus.mem2proc_data      = rdata;
    endtask

    // One bus cycle: apply inputs, check the combinational response, advance the model.
    task automatic step(input bit ireq, input logic [63:0] iaddr, input logic [1:0] dcmd,
                        input logic [63:0] daddr, input logic [63:0] ddata,
                        input logic [3:0] resp, input logic [3:0] rtag,
                        input logic [63:0] rdata);
        bit          dreq, fwin, dwin, stl;
        logic [1:0]  e_cmd;
        logic [63:0] e_addr, e_data;
        ret_t        r;
        @(negedge clock);
        drive(ireq, iaddr, dcmd, daddr, ddata, resp, rtag, rdata);
        #1;
        dreq   = (dcmd == 2'd1) || (dcmd == 2'd2);
        fwin   = ireq && (!dreq || starve == LIMIT);
        dwin   = dreq && !fwin;
        stl    = ireq && !(fwin && resp != 4'd0);
        e_cmd  = fwin ? 2'd1 : (dwin ? dcmd : 2'd0);
        e_addr = fwin ? iaddr : (dwin ? daddr : 64'd0);
        e_data = dwin ? ddata : 64'd0;
        chk("proc2mem_command", 64'(bus.proc2mem_command), 64'(e_cmd));
        chk("proc2mem_addr", bus.proc2mem_addr, e_addr);
        chk("proc2mem_data", bus.proc2mem_data, e_data);
        chk("Imem2proc_response", 64'(bus.Imem2proc_response), fwin ? 64'(resp) : 64'd0);
        chk("Dmem2proc_response", 64'(bus.Dmem2proc_response), dwin ? 64'(resp) : 64'd0);
        chk("stall", 64'(bus.memory_structure_hazard_stall), 64'(stl));
        obs_stall = bus.memory_structure_hazard_stall;
        obs_cmd   = bus.proc2mem_command;

        starve = stl ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
        if (rtag != 4'd0) begin
            if (owner[rtag] >= 0) begin
                r.is_data = (owner[rtag] == 1);
                r.data    = rdata;
                r.tag     = rtag;
                r.due     = cyc + 1;
                exp_q.push_back(r);
                owner[rtag] = -1;
            end else begin
                exp_tag_err = 1'b1;
            end
        end
        if (resp != 4'd0 && (fwin || (dwin && dcmd == 2'd1))) owner[resp] = fwin ? 0 : 1;
    endtask

    task automatic idle();
        step(1'b0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        drive(1'b0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
        reset = 1'b0;
        #1;
        chk("rst proc2mem_command", 64'(bus.proc2mem_command), 64'd0);
        chk("rst proc2mem_addr", bus.proc2mem_addr, 64'd0);
        chk("rst proc2mem_data", bus.proc2mem_data, 64'd0);
        chk("rst responses", {56'd0, bus.Imem2proc_response, bus.Dmem2proc_response}, 64'd0);
        chk("rst stall", 64'(bus.memory_structure_hazard_stall), 64'd0);
        chk("rst valids", {62'd0, bus.Imem2proc_valid, bus.Dmem2proc_valid}, 64'd0);
        chk("rst Imem2proc_data", bus.Imem2proc_data, 64'd0);
        chk("rst Dmem2proc_data", bus.Dmem2proc_data, 64'd0);
        chk("rst tags", {56'd0, bus.Imem2proc_tag, bus.Dmem2proc_tag}, 64'd0);
        chk("rst tag_error", 64'(bus.tag_error), 64'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    always @(negedge clock) begin
        if (reset) begin
            chk("tag_error", 64'(bus.tag_error), 64'(exp_tag_err));
            if (bus.Imem2proc_valid || bus.Dmem2proc_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_return", {62'd0, bus.Imem2proc_valid, bus.Dmem2proc_valid},
                        64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("return_side", {62'd0, bus.Imem2proc_valid, bus.Dmem2proc_valid},
                        mon_e.is_data ? 64'd1 : 64'd2);
                    chk("return_data", mon_e.is_data ? bus.Dmem2proc_data : bus.Imem2proc_data,
                        mon_e.data);
                    chk("return_tag", 64'(mon_e.is_data ? bus.Dmem2proc_tag : bus.Imem2proc_tag),
                        64'(mon_e.tag));
                    chk("return_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                mon_e = exp_q.pop_front();
                chk("missing_return", {62'd0, bus.Imem2proc_valid, bus.Dmem2proc_valid},
                    mon_e.is_data ? 64'd1 : 64'd2);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 50000", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        int outs[$];
        int frees[$];
        bit          ireq;
        logic [1:0]  dcmd;
        logic [3:0]  resp, rtag;
        int          r;
        model_reset();
        drive(1'b0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
        apply_reset();

        // Fetch alone, then its return.
        step(1'b1, 64'h100, 2'd0, 64'd0, 64'd0, 4'd3, 4'd0, 64'd0);
        step(1'b0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd3, 64'h1234_4567_5678_3456);
        idle();

        // Data load beats fetch.
        step(1'b1, 64'h140, 2'd1, 64'h2000, 64'd0, 4'd5, 4'd0, 64'd0);
        step(1'b0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd5, 64'hdead_beef_0000_0005);
        idle();

        // Continuous stores: fetch forced through on the fifth cycle.
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 64'h200, 2'd2, 64'h300 + 64'(i), 64'hab00 + 64'(i), 4'd10, 4'd0, 64'd0);
            if (i < 5 && obs_stall) n++;
            if (i == 4) chk("fetch_forced_cmd", 64'(obs_cmd), 64'd1);
        end
        chk("starve_stall_count", 64'(n), 64'd4);
        idle();

        // Rejected fetch, store with tag 7, then a stray return on 7.
        step(1'b1, 64'h400, 2'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
        step(1'b0, 64'd0, 2'd2, 64'h500, 64'h77, 4'd7, 4'd0, 64'd0);
        step(1'b0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd7, 64'h7777);
        idle();

        // Tag 9 returns to fetch in the same cycle a data load reuses it.
        step(1'b1, 64'h600, 2'd0, 64'd0, 64'd0, 4'd9, 4'd0, 64'd0);
        step(1'b0, 64'd0, 2'd1, 64'h700, 64'd0, 4'd9, 4'd9, 64'h9999_0000_1111_2222);
        step(1'b0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd9, 64'h9999_3333_4444_5555);
        idle();

        // Reset with loads outstanding; later returns are orphans.
        step(1'b1, 64'h800, 2'd0, 64'd0, 64'd0, 4'd1, 4'd0, 64'd0);
        step(1'b0, 64'd0, 2'd1, 64'h900, 64'd0, 4'd2, 4'd0, 64'd0);
        step(1'b1, 64'h880, 2'd0, 64'd0, 64'd0, 4'd4, 4'd0, 64'd0);
        apply_reset();
        step(1'b0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd1, 64'h1);
        step(1'b0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd2, 64'h2);
        step(1'b0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd4, 64'h4);
        idle();

        // Random traffic against the ownership model.
        apply_reset();
        for (int k = 0; k < 2000; k++) begin
            ireq = ($urandom_range(0, 99) < 60);
            dcmd = 2'($urandom_range(0, 3));
            outs.delete();
            for (int t = 1; t < 16; t++) if (owner[t] >= 0) outs.push_back(t);
            r    = $urandom_range(0, 99);
            rtag = 4'd0;
            if (r < 40 && outs.size() != 0) begin
                rtag = 4'(outs[$urandom_range(0, outs.size() - 1)]);
            end else if (r >= 97) begin
                frees.delete();
                for (int t = 1; t < 16; t++) if (owner[t] < 0) frees.push_back(t);
                if (frees.size() != 0) rtag = 4'(frees[$urandom_range(0, frees.size() - 1)]);
            end
            frees.delete();
            for (int t = 1; t < 16; t++) if (owner[t] < 0 && t != int'(rtag)) frees.push_back(t);
            r    = $urandom_range(0, 99);
            resp = 4'd0;
            if (!ireq && !(dcmd == 2'd1 || dcmd == 2'd2)) resp = 4'd0;
            else if (r < 20) resp = 4'd0;
            else if (r < 30 && rtag != 4'd0) resp = rtag;
            else if (frees.size() != 0) resp = 4'(frees[$urandom_range(0, frees.size() - 1)]);
            step(ireq, {$urandom, $urandom}, dcmd, {$urandom, $urandom}, {$urandom, $urandom},
                 resp, rtag, {$urandom, $urandom});
        end
        repeat (3) idle();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
